// File: rtl/solution_unloader_pkg.sv
// Shared solver package: problem dimensions, derived widths and the
// unloader state encoding used by the solver blocks.
package solution_unloader_pkg;

  localparam int unsigned N    = 16;         // unknowns per sweep
  localparam int unsigned XW   = 32;         // solution word width
  localparam int unsigned IW   = 8;          // iteration-count width
  localparam int unsigned IDXW = $clog2(N);  // index width (4 for N = 16)

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } unload_state_e;

endpackage : solution_unloader_pkg

// File: rtl/solution_buffer.sv
// N x XW capture buffer for the final sweep of a solve.
// Ports:
//   clk_in    - clock
//   we_in     - write enable
//   waddr_in  - write index
//   wdata_in  - write data
//   raddr_in  - read index (asynchronous read)
//   rdata_out - word stored at raddr_in
// Contents are not reset; every location is rewritten before it is read.
module solution_buffer
  import solution_unloader_pkg::*;
(
  input  logic            clk_in,
  input  logic            we_in,
  input  logic [IDXW-1:0] waddr_in,
  input  logic [XW-1:0]   wdata_in,
  input  logic [IDXW-1:0] raddr_in,
  output logic [XW-1:0]   rdata_out
);

  logic [XW-1:0] mem_q [N];

  // Single write port
  always_ff @(posedge clk_in) begin
    if (we_in) begin
      mem_q[waddr_in] <= wdata_in;
    end
  end

  // Asynchronous read port
  assign rdata_out = mem_q[raddr_in];

endmodule : solution_buffer

// File: rtl/solution_unloader.sv
// Captures the last Gauss-Seidel sweep of x words and streams it out
// through a valid/ready interface, then pulses done.
// Ports:
//   clk_in      - clock, rising edge
//   rst_in      - synchronous active-high reset
//   start_in    - one-cycle pulse, begins a solve (accepted in IDLE only)
//   iter_in     - sweep count, sampled with an accepted start (0 acts as 1)
//   x_valid_in  - x_in carries an updated word this cycle
//   x_in        - updated word, index order 0..N-1 per sweep
//   x_out       - final solution word offered downstream
//   x_valid_out - x_out is valid (DRAIN only)
//   x_ready_in  - downstream accepts x_out
//   x_last_out  - offered word is index N-1
//   busy_out    - block is not IDLE
//   done_out    - one-cycle pulse after the last word is accepted
module solution_unloader
  import solution_unloader_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic [IW-1:0] iter_in,
  input  logic          x_valid_in,
  input  logic [XW-1:0] x_in,
  output logic [XW-1:0] x_out,
  output logic          x_valid_out,
  input  logic          x_ready_in,
  output logic          x_last_out,
  output logic          busy_out,
  output logic          done_out
);

  unload_state_e   state_q, state_d;
  logic [IW-1:0]   iter_q,  iter_d;
  logic [IW-1:0]   sweep_q, sweep_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic [IDXW-1:0] rd_q,    rd_d;

  logic [XW-1:0]   x_out_q,   x_out_d;
  logic            x_valid_q, x_valid_d;
  logic            x_last_q,  x_last_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;

  logic            buf_we_c;
  logic            last_sweep_c;
  logic [XW-1:0]   buf_rdata_c;

  solution_buffer u_buf (
    .clk_in    (clk_in),
    .we_in     (buf_we_c),
    .waddr_in  (idx_q),
    .wdata_in  (x_in),
    .raddr_in  (rd_d),
    .rdata_out (buf_rdata_c)
  );

  // State and counter registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      iter_q    <= '0;
      sweep_q   <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      x_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      sweep_q   <= sweep_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      x_last_q  <= x_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    sweep_d   = sweep_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    buf_we_c  = 1'b0;

    // iter_q is never 0 once RUN is entered, so iter_q-1 cannot underflow
    last_sweep_c = (sweep_q == IW'(iter_q - IW'(1)));

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_RUN;
          iter_d  = (iter_in == '0) ? IW'(1) : iter_in;
          sweep_d = '0;
          idx_d   = '0;
        end
      end

      ST_RUN: begin
        if (x_valid_in) begin
          // Only the final sweep is kept; earlier sweeps just advance counters
          buf_we_c = last_sweep_c;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (last_sweep_c) begin
              state_d = ST_DRAIN;
              rd_d    = '0;
            end else begin
              sweep_d = IW'(sweep_q + IW'(1));
            end
          end else begin
            idx_d = IDXW'(idx_q + IDXW'(1));
          end
        end
      end

      ST_DRAIN: begin
        if (x_valid_q && x_ready_in) begin
          if (rd_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            rd_d = IDXW'(rd_q + IDXW'(1));
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state will present
    x_valid_d = (state_d == ST_DRAIN);
    x_last_d  = (state_d == ST_DRAIN) && (rd_d == LAST_IDX);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // Output word: buffer read at the next read index, held outside DRAIN.
  // Kept apart from the FSM block so the read path has no apparent loop.
  always_comb begin
    x_out_d = x_out_q;
    if (state_d == ST_DRAIN) begin
      x_out_d = buf_rdata_c;
    end
  end

  assign x_out       = x_out_q;
  assign x_valid_out = x_valid_q;
  assign x_last_out  = x_last_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;

endmodule : solution_unloader

// File: tb/tb_solution_unloader.sv
// Self-checking bench for solution_unloader. Reference model: the words
// expected downstream are exactly the N words of the final sweep, in order.
module tb_solution_unloader;
  import solution_unloader_pkg::*;

  logic          clk_in      = 1'b0;
  logic          rst_in      = 1'b1;
  logic          start_in    = 1'b0;
  logic [IW-1:0] iter_in     = '0;
  logic          x_valid_in  = 1'b0;
  logic [XW-1:0] x_in        = '0;
  logic [XW-1:0] x_out;
  logic          x_valid_out;
  logic          x_ready_in  = 1'b0;
  logic          x_last_out;
  logic          busy_out;
  logic          done_out;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_in = ~clk_in;

  solution_unloader dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .iter_in     (iter_in),
    .x_valid_in  (x_valid_in),
    .x_in        (x_in),
    .x_out       (x_out),
    .x_valid_out (x_valid_out),
    .x_ready_in  (x_ready_in),
    .x_last_out  (x_last_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word generator: 0 random, 1 0x100+i, 2 0x1000+s*16+i
  function automatic logic [XW-1:0] gen_word(input int pat, input int s, input int i);
    if (pat == 1) return 32'(32'h100 + i);
    if (pat == 2) return 32'(32'h1000 + s * 16 + i);
    return $urandom;
  endfunction

  // One complete solve. rmode: 0 ready always, 1 pattern 1,0,0, 2 random.
  // abort_at >= 0 asserts reset once that many words have been accepted.
  task automatic run_solve(input int iter, input int gap, input int rmode,
                           input bit stray, input int pat, input int abort_at);
    logic [XW-1:0] exp_q[$];
    logic [XW-1:0] w;
    int  eff;
    int  hs;
    int  cyc;
    bit  rdy;

    eff = (iter == 0) ? 1 : iter;

    @(negedge clk_in);
    check("idle_busy", 32'(busy_out), 32'd0);
    check("idle_valid", 32'(x_valid_out), 32'd0);

    if (stray) begin
      x_valid_in = 1'b1;
      x_in       = $urandom;
      @(negedge clk_in);
      x_valid_in = 1'b0;
      check("idle_stray_busy", 32'(busy_out), 32'd0);
    end

    start_in = 1'b1;
    iter_in  = IW'(iter);
    @(negedge clk_in);
    start_in = 1'b0;
    iter_in  = IW'($urandom);
    check("start_busy", 32'(busy_out), 32'd1);

    for (int s = 0; s < eff; s++) begin
      for (int i = 0; i < N; i++) begin
        w = gen_word(pat, s, i);
        if (s == eff - 1) exp_q.push_back(w);
        for (int g = 0; g < gap; g++) begin
          x_valid_in = 1'b0;
          x_in       = $urandom;
          @(negedge clk_in);
          check("run_gap_valid", 32'(x_valid_out), 32'd0);
          check("run_gap_busy", 32'(busy_out), 32'd1);
        end
        x_valid_in = 1'b1;
        x_in       = w;
        // A second start in the middle of the first sweep must be ignored
        if (stray && s == 0 && i == 5) begin
          start_in = 1'b1;
          iter_in  = IW'(7);
        end
        @(negedge clk_in);
        x_valid_in = 1'b0;
        start_in   = 1'b0;
        check("run_valid_out", 32'(x_valid_out), 32'((s == eff - 1) && (i == N - 1)));
      end
    end

    hs  = 0;
    cyc = 0;
    while (hs < N && cyc < 200) begin
      if (hs == abort_at) begin
        rst_in     = 1'b1;
        x_ready_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("abort_valid", 32'(x_valid_out), 32'd0);
        check("abort_busy", 32'(busy_out), 32'd0);
        check("abort_last", 32'(x_last_out), 32'd0);
        check("abort_done", 32'(done_out), 32'd0);
        check("abort_xout", x_out, 32'd0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk_in);
          check("abort_no_done", 32'(done_out), 32'd0);
          check("abort_idle", 32'(busy_out), 32'd0);
        end
        return;
      end
      check("drain_valid", 32'(x_valid_out), 32'd1);
      check("drain_data", x_out, exp_q[hs]);
      check("drain_last", 32'(x_last_out), 32'(hs == N - 1));
      check("drain_done", 32'(done_out), 32'd0);
      check("drain_busy", 32'(busy_out), 32'd1);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      x_ready_in = rdy;
      if (stray) begin
        x_valid_in = 1'($urandom_range(0, 1));
        x_in       = $urandom;
      end
      @(negedge clk_in);
      if (rdy) hs++;
      cyc++;
    end
    x_ready_in = 1'b0;
    x_valid_in = 1'b0;
    if (hs < N) check("drain_timeout", 32'(hs), 32'(N));

    check("done_pulse", 32'(done_out), 32'd1);
    check("done_valid", 32'(x_valid_out), 32'd0);
    check("done_busy", 32'(busy_out), 32'd1);
    @(negedge clk_in);
    check("done_clear", 32'(done_out), 32'd0);
    check("idle_after", 32'(busy_out), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_valid", 32'(x_valid_out), 32'd0);
    check("rst_last", 32'(x_last_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_xout", x_out, 32'd0);

    run_solve(1, 0, 0, 1'b0, 1, -1);   // single sweep, ready always
    run_solve(3, 0, 0, 1'b0, 2, -1);   // only the third sweep emitted
    run_solve(1, 0, 1, 1'b0, 1, -1);   // stalled drain, ready 1,0,0,...
    run_solve(2, 2, 0, 1'b1, 0, -1);   // gapped input, mid-run start, strays
    run_solve(0, 0, 0, 1'b0, 1, -1);   // iter 0 behaves as 1
    run_solve(1, 0, 0, 1'b0, 1, 7);    // reset at rd = 7
    run_solve(1, 0, 0, 1'b0, 2, -1);   // clean solve after abort

    for (int r = 0; r < 6; r++) begin
      run_solve(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_solution_unloader
